// File: rtl/multi_signal_stabilizer.sv
// multi_signal_stabilizer
//
// Stabilises WIDTH independent, possibly asynchronous and bouncing inputs.
// Each channel first passes through its own synchroniser chain. The synced
// value must then differ from the current output for 2^STABLE_TIME_LOG
// enabled cycles in a row before it is adopted. When it is adopted, a
// one-cycle rise or fall pulse is produced.
//
// Parameters:
//   WIDTH           number of independent channels (>= 1)
//   STABLE_TIME_LOG log2 of the required stable time in cycles (>= 1)
//   SYNC_STAGES     synchroniser depth per channel (1..4)
//   RESET_VALUE     value of so_o and of the synchroniser flops during reset
//
// Ports:
//   clock_i    system clock, rising edge
//   reset_i    asynchronous, active-high reset
//   en_i       count enable; when low, the stability counters hold
//   si_i       raw inputs, one bit per channel
//   so_o       stabilised outputs (registered)
//   rise_o     one-cycle pulse per channel on a so_o 0->1 change
//   fall_o     one-cycle pulse per channel on a so_o 1->0 change
//   changed_o  OR of all rise/fall pulses, aligned with them
module multi_signal_stabilizer #(
    parameter int               WIDTH           = 4,
    parameter int               STABLE_TIME_LOG = 3,
    parameter int               SYNC_STAGES     = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] si_i,
    output logic [WIDTH-1:0] so_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             changed_o
);

    logic [WIDTH-1:0] so_q,   so_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0]     sync_q, sync_d;
            logic [STABLE_TIME_LOG-1:0] cnt_q,  cnt_d;
            logic                       synced;
            logic                       differs;
            logic                       cnt_full;
            logic                       load;

            // Shift left so that bit 0 takes the raw input and the top bit
            // is the synced value. This works for any depth, including 1.
            always_comb begin
                sync_d    = sync_q << 1;
                sync_d[0] = si_i[gi];
            end

            assign synced   = sync_q[SYNC_STAGES-1];
            assign differs  = synced ^ so_q[gi];
            assign cnt_full = &cnt_q;
            // Adopt the new value on the cycle that would otherwise wrap
            // the counter. That cycle is the 2^STABLE_TIME_LOG-th enabled
            // cycle with a differing input.
            assign load     = differs & en_i & cnt_full;

            always_comb begin
                cnt_d = cnt_q;
                if (!differs) begin
                    // Any agreement, even for a single cycle, restarts the
                    // stable interval. This is independent of the enable.
                    cnt_d = '0;
                end else if (en_i) begin
                    cnt_d = cnt_full ? '0 : cnt_q + 1'b1;
                end
            end

            assign so_d[gi]   = load ? synced : so_q[gi];
            assign rise_d[gi] = load &  synced;
            assign fall_d[gi] = load & ~synced;

            always_ff @(posedge clock_i or posedge reset_i) begin
                if (reset_i) begin
                    sync_q <= {SYNC_STAGES{RESET_VALUE[gi]}};
                    cnt_q  <= '0;
                end else begin
                    sync_q <= sync_d;
                    cnt_q  <= cnt_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            so_q      <= RESET_VALUE;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            so_q      <= so_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= |(rise_d | fall_d);
        end
    end

    assign so_o      = so_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign changed_o = changed_q;

endmodule

// File: tb/tb_multi_signal_stabilizer.sv
module tb_multi_signal_stabilizer;

    localparam int         W     = 4;
    localparam int         STL   = 3;
    localparam int         SS    = 2;
    localparam logic [3:0] RV    = 4'b0000;
    localparam int         LIMIT = 1 << STL;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b1;
    logic [W-1:0] si  = '0;
    logic [W-1:0] so, rise, fall;
    logic         changed;

    int errors = 0;
    int checks = 0;

    multi_signal_stabilizer #(
        .WIDTH(W), .STABLE_TIME_LOG(STL), .SYNC_STAGES(SS), .RESET_VALUE(RV)
    ) dut (
        .clock_i(clk), .reset_i(rst), .en_i(en), .si_i(si),
        .so_o(so), .rise_o(rise), .fall_o(fall), .changed_o(changed)
    );

    always #5 clk = ~clk;

    // Behavioural reference. The history array delays the raw inputs by the
    // synchroniser depth. Each channel counts how many enabled cycles in a row
    // its synced input has disagreed with the output. On the LIMIT-th such
    // cycle the output adopts the input.
    logic [W-1:0] m_hist [SS];
    int           m_run  [W];
    logic [W-1:0] m_so, m_rise, m_fall;
    logic         m_changed;

    function automatic void model_reset();
        for (int k = 0; k < SS; k++) m_hist[k] = RV;
        for (int i = 0; i < W; i++) m_run[i] = 0;
        m_so = RV; m_rise = '0; m_fall = '0; m_changed = 1'b0;
    endfunction

    function automatic void model_edge();
        logic [W-1:0] s_now;
        if (rst) return;
        s_now  = m_hist[SS-1];
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < W; i++) begin
            if (s_now[i] == m_so[i]) begin
                m_run[i] = 0;
            end else if (en) begin
                if (m_run[i] + 1 == LIMIT) begin
                    m_so[i]  = s_now[i];
                    m_run[i] = 0;
                    if (s_now[i]) m_rise[i] = 1'b1;
                    else          m_fall[i] = 1'b1;
                end else begin
                    m_run[i] = m_run[i] + 1;
                end
            end
        end
        for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = si;
        m_changed = |(m_rise | m_fall);
    endfunction

    // Advance one rising edge and return 1 time unit after it.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Reset across two edges, released mid-cycle.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step();
        step();
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (so !== RV || rise !== '0 || fall !== '0 || changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: so=%b rise=%b fall=%b changed=%b required so=%b rest 0",
                     so, rise, fall, changed, RV);
        end
        model_reset();
        step();
        #2 rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (so !== RV || rise !== '0 || fall !== '0 || changed !== 1'b0) begin
                errors++;
                $display("FAIL reset_release k=%0d: so=%b rise=%b fall=%b changed=%b required idle",
                         k, so, rise, fall, changed);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_rise_latency();
        int pulses = 0;
        do_reset();
        si = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            logic [W-1:0] e_so, e_rise;
            step();
            e_so   = (k >= 10) ? 4'b0001 : 4'b0000;
            e_rise = (k == 10) ? 4'b0001 : 4'b0000;
            if (rise[0] === 1'b1) pulses++;
            checks++;
            if (so !== e_so || rise !== e_rise || fall !== '0 || changed !== (k == 10)) begin
                errors++;
                $display("FAIL rise_latency k=%0d: so=%b rise=%b fall=%b chg=%b required so=%b rise=%b fall=0000 chg=%0d",
                         k, so, rise, fall, changed, e_so, e_rise, (k == 10));
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL rise_pulse_count: got %0d required 1", pulses);
        end
        $display("test_rise_latency done");
    endtask

    task automatic test_glitch();
        int pulses = 0;
        do_reset();
        si = 4'b0010;
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) si = 4'b0000;
            step();
            if (rise[1] === 1'b1) pulses++;
            checks++;
            if (so !== 4'b0000) begin
                errors++;
                $display("FAIL glitch_early k=%0d: so=%b required 0000", k, so);
            end
        end
        si = 4'b0010;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (rise[1] === 1'b1) pulses++;
            checks++;
            if (so !== ((k >= 10) ? 4'b0010 : 4'b0000)) begin
                errors++;
                $display("FAIL glitch_latency k=%0d: so=%b required %b",
                         k, so, (k >= 10) ? 4'b0010 : 4'b0000);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL glitch_pulse_count: got %0d required 1", pulses);
        end
        $display("test_glitch done");
    endtask

    task automatic test_all_channels();
        do_reset();
        si = 4'b1111;
        for (int k = 1; k <= 12; k++) begin
            logic [W-1:0] e_so, e_rise;
            step();
            e_so   = (k >= 10) ? 4'b1111 : 4'b0000;
            e_rise = (k == 10) ? 4'b1111 : 4'b0000;
            checks++;
            if (so !== e_so || rise !== e_rise || changed !== (k == 10)) begin
                errors++;
                $display("FAIL all_channels k=%0d: so=%b rise=%b chg=%b required so=%b rise=%b chg=%0d",
                         k, so, rise, changed, e_so, e_rise, (k == 10));
            end
        end
        // Clearing must happen without waiting for a clock edge.
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (so !== RV || rise !== '0 || fall !== '0 || changed !== 1'b0) begin
            errors++;
            $display("FAIL async_clear: so=%b rise=%b fall=%b chg=%b required all 0",
                     so, rise, fall, changed);
        end
        step();
        #2 rst = 1'b0;
        $display("test_all_channels done");
    endtask

    task automatic test_enable_hold();
        do_reset();
        si = 4'b0100;
        for (int k = 1; k <= 32; k++) begin
            en = !(k >= 5 && k <= 24);
            step();
            checks++;
            if (so !== ((k >= 30) ? 4'b0100 : 4'b0000) || rise !== ((k == 30) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL enable_hold k=%0d: so=%b rise=%b required so=%b rise=%b",
                         k, so, rise, (k >= 30) ? 4'b0100 : 4'b0000, (k == 30) ? 4'b0100 : 4'b0000);
            end
        end
        en = 1'b1;
        $display("test_enable_hold done");
    endtask

    task automatic test_reset_midcount();
        do_reset();
        si = 4'b1000;
        for (int k = 1; k <= 7; k++) step();
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (so !== RV || rise !== '0 || changed !== 1'b0) begin
            errors++;
            $display("FAIL midcount_clear: so=%b rise=%b chg=%b required 0", so, rise, changed);
        end
        step();
        #2 rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (so !== ((k >= 10) ? 4'b1000 : 4'b0000) || rise !== ((k == 10) ? 4'b1000 : 4'b0000)) begin
                errors++;
                $display("FAIL midcount_latency k=%0d: so=%b rise=%b required so=%b rise=%b",
                         k, so, rise, (k >= 10) ? 4'b1000 : 4'b0000, (k == 10) ? 4'b1000 : 4'b0000);
            end
        end
        $display("test_reset_midcount done");
    endtask

    task automatic test_fall();
        do_reset();
        si = 4'b0001;
        for (int k = 1; k <= 12; k++) step();
        si = 4'b0000;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (so !== ((k >= 10) ? 4'b0000 : 4'b0001) || fall !== ((k == 10) ? 4'b0001 : 4'b0000) ||
                rise !== 4'b0000 || changed !== (k == 10)) begin
                errors++;
                $display("FAIL fall k=%0d: so=%b fall=%b rise=%b chg=%b required so=%b fall=%b rise=0000 chg=%0d",
                         k, so, fall, rise, changed, (k >= 10) ? 4'b0000 : 4'b0001,
                         (k == 10) ? 4'b0001 : 4'b0000, (k == 10));
            end
        end
        $display("test_fall done");
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) si = si ^ W'($urandom_range(1, (1 << W) - 1));
            en = ($urandom_range(0, 9) != 0);
            step();
            checks++;
            if (so !== m_so || rise !== m_rise || fall !== m_fall || changed !== m_changed) begin
                errors++;
                $display("FAIL random n=%0d: so=%b rise=%b fall=%b chg=%b required so=%b rise=%b fall=%b chg=%b",
                         n, so, rise, fall, changed, m_so, m_rise, m_fall, m_changed);
            end
            $display("txn %0d si=%b en=%b so=%b rise=%b fall=%b chg=%b", n, si, en, so, rise, fall, changed);
        end
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_glitch();
        test_all_channels();
        test_enable_hold();
        test_reset_midcount();
        test_fall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_signal_stabilizer.md
MULTI_SIGNAL_STABILIZER -- requirements
Module: multi_signal_stabilizer

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, the number of independent input channels (legal range >= 1).
REQ-002 SHALL provide parameter STABLE_TIME_LOG, default 3, the log2 of the required stable time in clock cycles (legal range >= 1).
REQ-003 SHALL provide parameter SYNC_STAGES, default 2, the number of input synchroniser flops per channel (legal range 1..4).
REQ-004 SHALL provide parameter RESET_VALUE, default all-zero, WIDTH bits, the value loaded into so and the synchroniser flops at reset.
REQ-005 clock  input  1  system clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  count enable; when low, all stability counters hold their value.
REQ-008 si  input  WIDTH  raw, possibly asynchronous and bouncing, inputs.
REQ-009 so  output  WIDTH  stabilised outputs, registered.
REQ-010 rise  output  WIDTH  per-channel one-cycle pulse on a so 0->1 transition, registered.
REQ-011 fall  output  WIDTH  per-channel one-cycle pulse on a so 1->0 transition, registered.
REQ-012 changed  output  1  OR of rise|fall, registered in the same cycle as those pulses.

Function
REQ-013 Each channel SHALL pass si[i] through a SYNC_STAGES-deep flop chain; the last stage is the synced value s[i].
REQ-014 Each channel SHALL own an unsigned STABLE_TIME_LOG-bit counter cnt[i]; there is no cross-channel coupling.
REQ-015 When s[i]==so[i], the channel SHALL clear cnt[i] to 0 on that edge, regardless of en.
REQ-016 When s[i]!=so[i] and en=1 and cnt[i] is not all-ones, the channel SHALL increment cnt[i] by 1.
REQ-017 When s[i]!=so[i] and en=1 and cnt[i] is all-ones, the channel SHALL load so[i]<=s[i] and clear cnt[i] to 0; the counter never wraps silently.
REQ-018 When s[i]!=so[i] and en=0, the channel SHALL hold cnt[i] and so[i].
REQ-019 A single cycle of s[i]==so[i] during counting SHALL restart the stable interval from 0 (glitch rejection).
REQ-020 Latency: with en=1, so[i] SHALL change on rising edge number SYNC_STAGES + 2^STABLE_TIME_LOG, counting as edge 1 the first edge that samples the new si value, provided si stays constant throughout.
REQ-021 rise[i] (fall[i]) SHALL be 1 for exactly the one cycle following the edge on which so[i] changes 0->1 (1->0), and 0 otherwise.
REQ-022 Channels changing on the same edge SHALL each assert their own pulse; changed SHALL be 1 for that single cycle.
REQ-023 Input pulses shorter than 2^STABLE_TIME_LOG synced cycles SHALL never reach so.

Reset
REQ-024 While reset=1, the block SHALL force synchroniser flops and so to RESET_VALUE, cnt to 0, rise, fall and changed to 0, immediately and without a clock edge.
REQ-025 Reset asserted mid-count SHALL discard all partial counts; after release, a changed input SHALL need the full REQ-020 latency.
REQ-026 No pulse SHALL be generated by reset assertion or release itself.

Verification (WIDTH=4, STABLE_TIME_LOG=3, SYNC_STAGES=2, RESET_VALUE=4'b0000, en=1 unless stated)
REQ-027 si[0] 0->1 held -> so[0]=1 after edge 10; rise[0]=1 for one cycle only; changed=1 for the same cycle; so[3:1], fall stay 0.
REQ-028 si[1] toggles 1 for 5 cycles, 0 for 1 cycle, then 1 held -> so[1] rises only 10 edges after the final 0->1 change; exactly one rise[1] pulse.
REQ-029 si=4'b1111 on one edge, held -> all so bits set on the same edge; rise=4'b1111 for one cycle; changed=1 for one cycle.
REQ-030 si[2]=1 held, en=0 for 20 cycles from edge 5 -> so[2] stays 0 throughout; after en=1, so[2] rises after the remaining count, with cnt held from edge 5.
REQ-031 si[3] 0->1, reset pulse at edge 7 of count -> so, cnt and pulses cleared asynchronously; so[3] rises 10 edges after reset release.
REQ-032 so[0]=1 settled, si[0] 1->0 held -> so[0]=0 after edge 10; fall[0] pulses for one cycle; rise stays 0.
